// File: rtl/packet_rx_check_if.sv
// Stream-in / FIFO-out bundle for packet_rx_check; the master side drives beats, the slave side (checker) drives the FIFO write.
interface packet_rx_check_if;
  logic        valid;
  logic        eof;
  logic [63:0] din;
  logic        fifo_full;
  logic        fifo_wr;
  logic [63:0] fifo_din;

  modport master (
    output valid, eof, din, fifo_full,
    input  fifo_wr, fifo_din
  );

  modport slave (
    input  valid, eof, din, fifo_full,
    output fifo_wr, fifo_din
  );
endinterface

// File: rtl/packet_rx_check.sv
// Packet length/overflow/timeout checker forwarding beats to a FIFO; define PKT_RX_STATS_EN to add pkt/err counters.
// Latency 1 cycle din->fifo_din; no backpressure upstream: beats seen while fifo_full is high are dropped and flagged.
module packet_rx_check #(
  parameter logic [31:0] TIMEOUT = 32'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_i,
  input  logic [13:0]       period_i,
  packet_rx_check_if.slave  bus,
  output logic              pkt_done_o,
  output logic              len_err_o,
  output logic              ovf_err_o,
  output logic              tmo_err_o,
  output logic [14:0]       word_cnt_o
`ifdef PKT_RX_STATS_EN
  ,
  output logic [31:0]       pkt_cnt_o,
  output logic [31:0]       err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] exp_len_q, exp_len_d;
  logic [14:0] word_cnt_q, word_cnt_d;
  logic [31:0] gap_q, gap_d;
  logic        bad_q, bad_d;
  logic        fifo_wr_q, fifo_wr_d;
  logic [63:0] fifo_din_q, fifo_din_d;
  logic        pkt_done_q, pkt_done_d;
  logic        len_err_q, len_err_d;
  logic        ovf_err_q, ovf_err_d;
  logic        tmo_err_q, tmo_err_d;

  logic        beat;
  logic        eof;
  logic        full;
  logic        gap_tick;
  logic        timeout_hit;
  logic [14:0] period_len;
  logic [14:0] cnt_inc;

  assign beat        = ce_i & bus.valid;
  assign eof         = bus.eof;
  assign full        = bus.fifo_full;
  assign gap_tick    = ce_i & ~bus.valid & ((state_q == S_RECV) | (state_q == S_DRAIN));
  assign timeout_hit = gap_tick & ((gap_q + 32'd1) == TIMEOUT);
  // A period of zero encodes the maximum packet length.
  assign period_len  = (period_i == 14'd0) ? 15'd16384 : {1'b0, period_i};
  assign cnt_inc     = word_cnt_q + 15'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (beat && !eof) state_d = S_RECV;
      end
      S_RECV: begin
        if (beat) begin
          if (eof)                           state_d = S_IDLE;
          else if (word_cnt_q == exp_len_q)  state_d = S_DRAIN;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if ((beat && eof) || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_d  = 1'b0;
    fifo_din_d = fifo_din_q;
    pkt_done_d = 1'b0;
    len_err_d  = 1'b0;
    ovf_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    word_cnt_d = word_cnt_q;
    exp_len_d  = exp_len_q;
    bad_d      = bad_q;
    gap_d      = gap_q;
    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (beat) begin
          exp_len_d  = period_len;
          word_cnt_d = 15'd1;
          bad_d      = full;
          fifo_wr_d  = ~full;
          ovf_err_d  = full;
          if (!full) fifo_din_d = bus.din;
          if (eof) begin
            pkt_done_d = (period_len == 15'd1) && !full;
            len_err_d  = (period_len != 15'd1);
          end
        end
      end
      S_RECV: begin
        if (beat) begin
          gap_d = '0;
          // Overlong packet: the extra beat is refused and the rest of it drained.
          if (!eof && (word_cnt_q == exp_len_q)) begin
            len_err_d = 1'b1;
          end else begin
            word_cnt_d = cnt_inc;
            bad_d      = bad_q | full;
            fifo_wr_d  = ~full;
            ovf_err_d  = full;
            if (!full) fifo_din_d = bus.din;
            if (eof) begin
              pkt_done_d = (cnt_inc == exp_len_q) && !(bad_q | full);
              len_err_d  = (cnt_inc != exp_len_q);
            end
          end
        end else if (timeout_hit) begin
          tmo_err_d  = 1'b1;
          word_cnt_d = '0;
          gap_d      = '0;
        end else if (gap_tick) begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_DRAIN: begin
        if (beat) begin
          gap_d = '0;
        end else if (timeout_hit) begin
          tmo_err_d  = 1'b1;
          word_cnt_d = '0;
          gap_d      = '0;
        end else if (gap_tick) begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: gap_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_len_q  <= '0;
      word_cnt_q <= '0;
      gap_q      <= '0;
      bad_q      <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_din_q <= '0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      exp_len_q  <= exp_len_d;
      word_cnt_q <= word_cnt_d;
      gap_q      <= gap_d;
      bad_q      <= bad_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_din_q <= fifo_din_d;
      pkt_done_q <= pkt_done_d;
      len_err_q  <= len_err_d;
      ovf_err_q  <= ovf_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign bus.fifo_wr  = fifo_wr_q;
  assign bus.fifo_din = fifo_din_q;
  assign pkt_done_o   = pkt_done_q;
  assign len_err_o    = len_err_q;
  assign ovf_err_o    = ovf_err_q;
  assign tmo_err_o    = tmo_err_q;
  assign word_cnt_o   = word_cnt_q;

`ifdef PKT_RX_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done_d) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (len_err_d | ovf_err_d | tmo_err_d) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_packet_rx_check.sv
// Randomized and directed bench for packet_rx_check against a packet-level reference model.
module tb_packet_rx_check;
  localparam logic [31:0] TMO = 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic [13:0] period = 14'd4;
  logic        pkt_done, len_err, ovf_err, tmo_err;
  logic [14:0] word_cnt;
`ifdef PKT_RX_STATS_EN
  logic [31:0] pkt_cnt, err_cnt;
  int          m_pkt, m_err;
`endif

  packet_rx_check_if bus ();

  packet_rx_check #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce_i       (ce),
    .period_i   (period),
    .bus        (bus),
    .pkt_done_o (pkt_done),
    .len_err_o  (len_err),
    .ovf_err_o  (ovf_err),
    .tmo_err_o  (tmo_err),
    .word_cnt_o (word_cnt)
`ifdef PKT_RX_STATS_EN
    ,
    .pkt_cnt_o  (pkt_cnt),
    .err_cnt_o  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet-level bookkeeping
  bit          m_open, m_drain, m_bad, cnt_known;
  int          m_cnt, m_exp, m_gap;
  bit          e_wr, e_done, e_len, e_ovf, e_tmo;
  logic [63:0] e_din;
  int          obs_wr, obs_done, obs_len, obs_ovf, obs_tmo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    e_wr = 0; e_done = 0; e_len = 0; e_ovf = 0; e_tmo = 0;
    if (reset) begin
      m_open = 0; m_drain = 0; m_bad = 0; m_cnt = 0; m_gap = 0; m_exp = 0; cnt_known = 1;
`ifdef PKT_RX_STATS_EN
      m_pkt = 0; m_err = 0;
`endif
    end else if (ce) begin
      if (bus.valid) begin
        m_gap = 0;
        if (m_drain) begin
          if (bus.eof) m_drain = 0;
        end else begin
          if (!m_open) begin
            m_exp = (period == 0) ? 16384 : int'(period);
            m_cnt = 0;
            m_bad = 0;
          end
          if (m_open && !bus.eof && m_cnt == m_exp) begin
            e_len = 1; m_open = 0; m_drain = 1; cnt_known = 0;
          end else begin
            m_cnt++;
            cnt_known = 1;
            if (bus.fifo_full) begin
              e_ovf = 1; m_bad = 1;
            end else begin
              e_wr = 1; e_din = bus.din;
            end
            if (bus.eof) begin
              if (m_cnt == m_exp) e_done = !m_bad;
              else                e_len = 1;
              m_open = 0; cnt_known = 0;
            end else begin
              m_open = 1;
            end
          end
        end
      end else if (m_open || m_drain) begin
        m_gap++;
        if (m_gap == int'(TMO)) begin
          e_tmo = 1; m_open = 0; m_drain = 0; m_cnt = 0; m_gap = 0; cnt_known = 1;
        end
      end
    end
`ifdef PKT_RX_STATS_EN
    if (!reset) begin
      if (e_done) m_pkt++;
      if (e_len || e_ovf || e_tmo) m_err++;
    end
`endif
  endtask

  task automatic cyc(input logic v, input logic e, input logic f, input logic [63:0] d);
    bus.valid = v; bus.eof = e; bus.fifo_full = f; bus.din = d;
    model_step();
    @(posedge clk);
    #1;
    check_eq("fifo_wr", 64'(bus.fifo_wr), 64'(e_wr));
    check_eq("pkt_done", 64'(pkt_done), 64'(e_done));
    check_eq("len_err", 64'(len_err), 64'(e_len));
    check_eq("ovf_err", 64'(ovf_err), 64'(e_ovf));
    check_eq("tmo_err", 64'(tmo_err), 64'(e_tmo));
    if (e_wr)      check_eq("fifo_din", bus.fifo_din, e_din);
    if (reset)     check_eq("fifo_din_rst", bus.fifo_din, 64'd0);
    if (cnt_known) check_eq("word_cnt", 64'(word_cnt), 64'(m_cnt));
`ifdef PKT_RX_STATS_EN
    check_eq("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    check_eq("err_cnt", 64'(err_cnt), 64'(m_err));
`endif
    obs_wr   += int'(bus.fifo_wr);
    obs_done += int'(pkt_done);
    obs_len  += int'(len_err);
    obs_ovf  += int'(ovf_err);
    obs_tmo  += int'(tmo_err);
  endtask

  task automatic clr_obs();
    obs_wr = 0; obs_done = 0; obs_len = 0; obs_ovf = 0; obs_tmo = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic rnd_beat(input logic e, input logic f);
    cyc(1'b1, e, f, {$urandom, $urandom});
  endtask

  initial begin
    bus.valid = 0; bus.eof = 0; bus.fifo_full = 0; bus.din = '0;
    reset = 1;
    idle(2);
    reset = 0;

    clr_obs(); period = 14'd4;
    for (int i = 1; i <= 4; i++) cyc(1'b1, i == 4, 1'b0, 64'(i));
    idle(1);
    check_eq("basic_writes", 64'(obs_wr), 64'd4);
    check_eq("basic_done", 64'(obs_done), 64'd1);
    check_eq("basic_errs", 64'(obs_len + obs_ovf + obs_tmo), 64'd0);

    clr_obs();
    for (int i = 1; i <= 3; i++) rnd_beat(i == 3, 1'b0);
    idle(1);
    check_eq("short_writes", 64'(obs_wr), 64'd3);
    check_eq("short_len", 64'(obs_len), 64'd1);
    check_eq("short_done", 64'(obs_done), 64'd0);

    clr_obs();
    for (int i = 1; i <= 6; i++) rnd_beat(i == 6, 1'b0);
    idle(1);
    check_eq("long_writes", 64'(obs_wr), 64'd4);
    check_eq("long_len", 64'(obs_len), 64'd1);

    clr_obs(); period = 14'd1;
    rnd_beat(1'b1, 1'b0);
    idle(1);
    check_eq("single_done", 64'(obs_done), 64'd1);

    clr_obs(); period = 14'd2;
    rnd_beat(1'b0, 1'b1);
    rnd_beat(1'b1, 1'b0);
    idle(1);
    check_eq("ovf_pulse", 64'(obs_ovf), 64'd1);
    check_eq("ovf_writes", 64'(obs_wr), 64'd1);
    check_eq("ovf_nodone", 64'(obs_done + obs_len), 64'd0);

    clr_obs();
    rnd_beat(1'b0, 1'b0);
    rnd_beat(1'b1, 1'b1);
    idle(1);
    check_eq("eof_full_ovf", 64'(obs_ovf), 64'd1);
    check_eq("eof_full_quiet", 64'(obs_done + obs_len), 64'd0);

    clr_obs(); period = 14'd4;
    rnd_beat(1'b0, 1'b0);
    idle(8);
    check_eq("tmo_pulse", 64'(obs_tmo), 64'd1);
    check_eq("tmo_wcnt", 64'(word_cnt), 64'd0);
    rnd_beat(1'b0, 1'b0);
    check_eq("tmo_restart", 64'(word_cnt), 64'd1);
    idle(8);

    clr_obs(); period = 14'd3;
    rnd_beat(1'b0, 1'b0);
    ce = 0;
    for (int i = 0; i < 3; i++) rnd_beat(1'b0, 1'b0);
    check_eq("ce_hold_wcnt", 64'(word_cnt), 64'd1);
    ce = 1;
    rnd_beat(1'b0, 1'b0);
    rnd_beat(1'b1, 1'b0);
    idle(1);
    check_eq("ce_writes", 64'(obs_wr), 64'd3);
    check_eq("ce_done", 64'(obs_done), 64'd1);

    clr_obs(); period = 14'd3;
    rnd_beat(1'b0, 1'b0);
    period = 14'd5;
    rnd_beat(1'b0, 1'b0);
    rnd_beat(1'b1, 1'b0);
    idle(1);
    check_eq("period_latched", 64'(obs_done), 64'd1);

    clr_obs(); period = 14'd6;
    rnd_beat(1'b0, 1'b0);
    rnd_beat(1'b0, 1'b0);
    reset = 1;
    rnd_beat(1'b0, 1'b0);
    reset = 0;
    idle(12);
    check_eq("rst_mid_quiet", 64'(obs_len + obs_tmo + obs_done), 64'd0);

    clr_obs(); period = 14'd0;
    for (int i = 0; i < 16384; i++) cyc(1'b1, i == 16383, 1'b0, 64'(i));
    idle(1);
    check_eq("max_writes", 64'(obs_wr), 64'd16384);
    check_eq("max_done", 64'(obs_done), 64'd1);
    check_eq("max_len", 64'(obs_len), 64'd0);

    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = (blk % 2 == 0) ? 85 : 35;
      for (int i = 0; i < 500; i++) begin
        reset = ($urandom_range(0, 299) == 0);
        ce    = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 39) == 0) period = 14'($urandom_range(0, 6));
        cyc($urandom_range(0, 99) < dens, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 10, {$urandom, $urandom});
      end
    end
    reset = 0; ce = 1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_rx_check.md
PACKET_RX_CHECK -- requirements
Module: packet_rx_check

Interface
REQ-001 The block SHALL have one clock, clk, and reset, reset, which is synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 32'd1024: idle cycles allowed between beats inside a packet.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 ce  input  1  clock enable; low = hold state.
REQ-006 din  input  64  stream data beat.
REQ-007 valid  input  1  din carries a beat this cycle.
REQ-008 eof  input  1  qualified by valid; the beat is the last beat of the packet.
REQ-009 period  input  14  expected beats per packet; 0 means 16384.
REQ-010 fifo_full  input  1  downstream FIFO cannot accept a write.
REQ-011 fifo_wr  output  1  registered write strobe to the downstream FIFO.
REQ-012 fifo_din  output  64  registered write data.
REQ-013 pkt_done  output  1  one-cycle pulse: packet received with correct length and no drops.
REQ-014 len_err  output  1  one-cycle pulse: packet length mismatch.
REQ-015 ovf_err  output  1  one-cycle pulse: beat dropped because fifo_full was high.
REQ-016 tmo_err  output  1  one-cycle pulse: in-packet gap reached TIMEOUT.
REQ-017 word_cnt  output  15  beats accepted in the current packet.

Function
REQ-018 States SHALL be IDLE, RECV and DRAIN; any undefined encoding SHALL go to IDLE.
REQ-019 Beat handling: a beat (valid=1, ce=1) with fifo_full=0 in IDLE or RECV SHALL produce fifo_wr=1 and fifo_din=din on the next cycle, so latency is 1 cycle.
REQ-020 Dropped beats: a beat with fifo_full=1 SHALL NOT be written, SHALL pulse ovf_err, SHALL still be counted, and SHALL set a sticky bad flag for the packet.
REQ-021 IDLE, first beat: period SHALL be latched into exp_len (0 latched as 16384), word_cnt SHALL be set to 1, and the bad flag cleared.
REQ-022 IDLE, first beat without eof: the next state SHALL be RECV.
REQ-023 IDLE, first beat with eof: the packet SHALL close as in REQ-025, and the state SHALL stay IDLE.
REQ-024 RECV, beat without eof: word_cnt SHALL increment; if word_cnt already equals exp_len, the block SHALL pulse len_err, perform no write, and go to DRAIN.
REQ-025 RECV, beat with eof (close): the state SHALL go to IDLE; if word_cnt+1==exp_len and bad=0, pulse pkt_done; if the length mismatches, pulse len_err; if the length matches and bad=1, pulse neither.
REQ-026 DRAIN: beats SHALL be discarded with no fifo_wr and no count change; a beat with eof SHALL return the state to IDLE.
REQ-027 Gap counter: in RECV and DRAIN, each cycle with ce=1 and valid=0 SHALL increment a gap counter, and any beat SHALL clear it.
REQ-028 Timeout: when the gap counter reaches TIMEOUT, the block SHALL pulse tmo_err, go to IDLE, and clear word_cnt; the gap counter SHALL NOT count in IDLE.
REQ-029 Pulse width: all pulse outputs and fifo_wr SHALL default to 0 every cycle, with at most one cycle high per event.
REQ-030 ce=0: fifo_wr and all pulses SHALL be 0, all other registers SHALL hold, and input beats SHALL be ignored.
REQ-031 Mid-packet changes to period SHALL NOT affect the current packet.
REQ-032 Simultaneous events: a beat with eof and fifo_full=1 SHALL pulse ovf_err, and the close SHALL then follow REQ-025 with bad=1.

Reset
REQ-033 While reset=1, the state SHALL be IDLE; fifo_wr, fifo_din, pkt_done, len_err, ovf_err, tmo_err, word_cnt, the gap counter, exp_len and bad SHALL be 0.
REQ-034 Reset SHALL take precedence over ce, and a reset mid-packet SHALL abandon the packet with no error pulse.

Configuration
REQ-035 Macro PKT_RX_STATS_EN: when defined, the block SHALL add 32-bit outputs pkt_cnt (incremented per pkt_done) and err_cnt (incremented per len_err, ovf_err or tmo_err pulse, at most +1 per cycle), both reset to 0 and wrapping at 2^32.
REQ-036 Without PKT_RX_STATS_EN: these ports and counters SHALL NOT exist, and the remaining behaviour SHALL be identical.

Verification
REQ-037 period=4, 4 beats 0x1..0x4 with eof on the 4th -> fifo_wr on 4 cycles, 1 cycle late, with data 0x1..0x4; one pkt_done; no errors.
REQ-038 period=4, eof on the 3rd beat -> 3 writes, len_err once, no pkt_done; period=4, 6 beats -> 4 writes, len_err at the 5th beat, the 6th beat (eof) discarded, state IDLE.
REQ-039 period=2, fifo_full=1 on the 1st beat -> ovf_err, one write only, no pkt_done, no len_err.
REQ-040 TIMEOUT=8, 1 beat then valid=0 for 8 cycles -> tmo_err pulse, word_cnt=0; the next beat starts a new packet.
REQ-041 period=0 -> 16384 beats closed by eof give pkt_done; period=1 with a single eof beat gives pkt_done; ce=0 during beats -> no writes and state held; reset mid-packet -> all outputs 0.
